// File: rtl/haz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters in the top are enabled with HAZ_PERF_CNT_EN.
package haz_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } haz_state_t;

   localparam int unsigned FLUSH_W     = 3;
   localparam int unsigned FLUSH_IFID  = 0;
   localparam int unsigned FLUSH_IDEX  = 1;
   localparam int unsigned FLUSH_EXMEM = 2;

   // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 7
   localparam int unsigned STALL_CNT_W = 3;

   // Redirect flush pattern: the youngest 'depth' buffers
   function automatic logic [FLUSH_W-1:0] flush_mask(input int unsigned depth);
      logic [FLUSH_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < FLUSH_W; i++) begin
         if (i < depth) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/haz_fwd_sel.sv
// Forwarding source select for one EX operand; the MEM result is younger
// than the WB result, so it wins when both match.
module haz_fwd_sel
   import haz_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output fwd_sel_t          sel
);

   always_comb begin
      sel = FWD_NONE;
      if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) sel = FWD_WB;
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) sel = FWD_MEM;
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, redirect flush and EX forwarding control for the 5-stage pipe.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_hazard_unit
   import haz_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned FLUSH_DEPTH = 3,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic              br_taken,
   input  logic              jump_taken,
   output logic              pc_en,
   output logic              ifid_en,
   output logic [FLUSH_W-1:0] flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
`endif
);

   localparam logic [FLUSH_W-1:0]     FLUSH_MASK = flush_mask(FLUSH_DEPTH);
   localparam logic [STALL_CNT_W-1:0] LAT_M1     = STALL_CNT_W'(LOAD_LAT - 1);

   if (LOAD_LAT < 1 || LOAD_LAT > 7 || FLUSH_DEPTH < 1 || FLUSH_DEPTH > 3 || CNT_W < 1)
   begin : g_bad_param
      $error("pipe_hazard_unit: parameter out of range");
   end

   haz_state_t             state_q, state_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   busy_q;
   logic                   detect;
   logic                   redirect;
   fwd_sel_t               sel_a, sel_b;

   assign redirect = br_taken | jump_taken;
   assign detect   = id_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   haz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .src          (ex_rs),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (sel_a)
   );

   haz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .src          (ex_rt),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (sel_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == STALL);
      end
   end

   // The first bubble is issued from RUN, so STALL covers the remaining LOAD_LAT-1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (redirect) begin
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (detect && (LOAD_LAT > 1)) begin
                  state_d = STALL;
                  cnt_d   = LAT_M1;
               end
            end
            STALL: begin
               if (cnt_q <= STALL_CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - STALL_CNT_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs follow rst directly so the pipe is frozen and flushed during reset
   always_comb begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      flush   = '0;
      fwd_a   = 2'(sel_a);
      fwd_b   = 2'(sel_b);
      if (rst) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         flush   = '1;
         fwd_a   = 2'(FWD_NONE);
         fwd_b   = 2'(FWD_NONE);
      end else if (redirect) begin
         flush = FLUSH_MASK;
      end else if ((state_q == STALL) || detect) begin
         pc_en             = 1'b0;
         ifid_en           = 1'b0;
         flush[FLUSH_IDEX] = 1'b1;
      end
   end

   assign busy = busy_q;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
         if (redirect && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (LOAD_LAT=1 and 3) against a bubble-count model.
// Compile with HAZ_PERF_CNT_EN to also check the performance counters.
module tb_pipe_hazard_unit;

   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_uses_rt;
   logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic          ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
   logic          br_taken, jump_taken;

   logic       pc_en_1, ifid_en_1, busy_1, pc_en_3, ifid_en_3, busy_3;
   logic [2:0] flush_1, flush_3;
   logic [1:0] fwd_a_1, fwd_b_1, fwd_a_3, fwd_b_3;
`ifdef HAZ_PERF_CNT_EN
   logic [1:0]  sc_1, fe_1;
   logic [15:0] sc_3, fe_3;
`endif

   int total = 0;
   int bad   = 0;
   // Model: bubbles still owed after the current cycle's decision, per instance
   int r1 = 0, r3 = 0;
   int m_sc1 = 0, m_fe1 = 0, m_sc3 = 0, m_fe3 = 0;

   always #5 clk = ~clk;

   pipe_hazard_unit #(.REG_AW(AW), .LOAD_LAT(1), .FLUSH_DEPTH(2), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .br_taken(br_taken), .jump_taken(jump_taken), .pc_en(pc_en_1),
      .ifid_en(ifid_en_1), .flush(flush_1), .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
      .busy(busy_1)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(sc_1), .flush_events(fe_1)
`endif
   );

   pipe_hazard_unit #(.REG_AW(AW), .LOAD_LAT(3), .FLUSH_DEPTH(3), .CNT_W(16)) u_dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .br_taken(br_taken), .jump_taken(jump_taken), .pc_en(pc_en_3),
      .ifid_en(ifid_en_3), .flush(flush_3), .fwd_a(fwd_a_3), .fwd_b(fwd_b_3),
      .busy(busy_3)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(sc_3), .flush_events(fe_3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_detect();
      return id_valid && ex_memread && ex_regwrite && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
   endfunction

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
      if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
      if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_stall(input int r);
      return !rst && !(br_taken || jump_taken) && (r > 0 || m_detect());
   endfunction

   function automatic int m_next(input int r, input int lat);
      if (br_taken || jump_taken) return 0;
      if (r > 0) return r - 1;
      if (m_detect()) return lat - 1;
      return 0;
   endfunction

   task automatic check_inst(input string n, input int r, input int depth,
                             input logic pc, input logic ifid, input logic [2:0] fl,
                             input logic [1:0] fa, input logic [1:0] fb, input logic bz);
      logic [2:0] efl;
      logic       epc;
      epc = !m_stall(r);
      if (rst) efl = 3'b111;
      else if (br_taken || jump_taken) efl = 3'((1 << depth) - 1);
      else if (m_stall(r)) efl = 3'b010;
      else efl = 3'b000;
      if (rst) epc = 1'b0;
      chk({n, ".pc_en"}, 32'(pc), 32'(epc));
      chk({n, ".ifid_en"}, 32'(ifid), 32'(epc));
      chk({n, ".flush"}, 32'(fl), 32'(efl));
      chk({n, ".fwd_a"}, 32'(fa), rst ? 32'd0 : 32'(m_fwd(ex_rs)));
      chk({n, ".fwd_b"}, 32'(fb), rst ? 32'd0 : 32'(m_fwd(ex_rt)));
      chk({n, ".busy"}, 32'(bz), 32'(!rst && r > 0));
   endtask

   task automatic check_all();
      check_inst("lat1", r1, 2, pc_en_1, ifid_en_1, flush_1, fwd_a_1, fwd_b_1, busy_1);
      check_inst("lat3", r3, 3, pc_en_3, ifid_en_3, flush_3, fwd_a_3, fwd_b_3, busy_3);
`ifdef HAZ_PERF_CNT_EN
      chk("lat1.stall_cycles", 32'(sc_1), 32'(m_sc1));
      chk("lat1.flush_events", 32'(fe_1), 32'(m_fe1));
      chk("lat3.stall_cycles", 32'(sc_3), 32'(m_sc3));
      chk("lat3.flush_events", 32'(fe_3), 32'(m_fe3));
`endif
   endtask

   // Check mid-cycle, then advance the model at the same edge as the DUT
   task automatic step();
      logic s1, s3, rd;
      @(negedge clk);
      check_all();
      s1 = m_stall(r1);
      s3 = m_stall(r3);
      rd = br_taken || jump_taken;
      @(posedge clk);
      if (!rst) begin
         if (s1) m_sc1 = (m_sc1 < 3) ? m_sc1 + 1 : 3;
         if (s3) m_sc3 = (m_sc3 < 65535) ? m_sc3 + 1 : 65535;
         if (rd) begin
            m_fe1 = (m_fe1 < 3) ? m_fe1 + 1 : 3;
            m_fe3 = (m_fe3 < 65535) ? m_fe3 + 1 : 65535;
         end
         r1 = m_next(r1, 1);
         r3 = m_next(r3, 3);
      end
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b1; id_uses_rt = 1'b1;
      id_rs = 5'd1; id_rt = 5'd2; ex_rs = 5'd3; ex_rt = 5'd6; ex_rd = 5'd7;
      ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
      br_taken = 1'b0; jump_taken = 1'b0;
   endtask

   task automatic load_use(input logic [AW-1:0] rd);
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
   endtask

   // Asynchronous reset pulse, checked before any clock edge
   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      r1 = 0; r3 = 0; m_sc1 = 0; m_fe1 = 0; m_sc3 = 0; m_fe3 = 0;
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #1 check_all();
      step();
      rst = 1'b0;

      // Load-use on rs, held one cycle then removed
      load_use(5'd5); id_rs = 5'd5;
      step();
      idle();
      repeat (4) step();

      // rd == 0 never stalls; rt match ignored unless the instruction reads rt
      load_use(5'd0); id_rs = 5'd0;
      step();
      idle(); load_use(5'd5); id_rt = 5'd5; id_uses_rt = 1'b0;
      step();
      id_uses_rt = 1'b1;
      step();
      idle();
      repeat (3) step();

      // Forwarding priority and register 0
      ex_rs = 5'd4; ex_rt = 5'd4; mem_rd = 5'd4; wb_rd = 5'd4;
      mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      step();
      chk("fwd_a_mem_prio", 32'(fwd_a_3), 32'd2);
      mem_regwrite = 1'b0;
      step();
      mem_regwrite = 1'b1; mem_rd = 5'd0;
      step();
      chk("fwd_a_wb_rd0", 32'(fwd_a_1), 32'd1);
      idle();

      // Branch during the second stall cycle aborts the stall
      load_use(5'd9); id_rs = 5'd9;
      step();
      idle(); br_taken = 1'b1;
      step();
      br_taken = 1'b0;
      repeat (2) step();

      // Jump together with a fresh hazard: redirect wins
      load_use(5'd9); id_rt = 5'd9; jump_taken = 1'b1;
      step();
      idle();
      step();

      // Reset in the middle of a stall, then no residual bubbles
      load_use(5'd11); id_rs = 5'd11;
      step();
      idle();
      rst_pulse();
      repeat (3) step();

      // Randomized traffic with small register numbers to provoke matches
      for (int i = 0; i < 400; i++) begin
         id_valid     = ($urandom_range(0, 9) < 8);
         id_uses_rt   = $urandom_range(0, 1) == 1;
         id_rs        = AW'($urandom_range(0, 7));
         id_rt        = AW'($urandom_range(0, 7));
         ex_rs        = AW'($urandom_range(0, 7));
         ex_rt        = AW'($urandom_range(0, 7));
         ex_rd        = AW'($urandom_range(0, 7));
         ex_regwrite  = ($urandom_range(0, 9) < 7);
         ex_memread   = ($urandom_range(0, 9) < 4);
         mem_rd       = AW'($urandom_range(0, 7));
         mem_regwrite = $urandom_range(0, 1) == 1;
         wb_rd        = AW'($urandom_range(0, 7));
         wb_regwrite  = $urandom_range(0, 1) == 1;
         br_taken     = ($urandom_range(0, 19) < 2);
         jump_taken   = ($urandom_range(0, 19) == 0);
         step();
      end

      // Three bubbles plus one redirect from a clean start
      idle();
      rst_pulse();
      load_use(5'd5); id_rs = 5'd5;
      step();
      idle();
      repeat (4) step();
      br_taken = 1'b1;
      step();
      br_taken = 1'b0;
      step();
`ifdef HAZ_PERF_CNT_EN
      chk("perf_stall_cycles", 32'(sc_3), 32'd3);
      chk("perf_flush_events", 32'(fe_3), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
